// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract core: the carry chain is cut into STAGES chunks, one per stage.
// Optional signed saturation is built when ADDSUB_PIPE_SAT_EN is defined (adds the sat input).
module addsub_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  input  logic             carry_in,
`ifdef ADDSUB_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;
`ifdef ADDSUB_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("addsub_pipe: STAGES must be in 1..WIDTH");
  end
  if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("addsub_pipe: WIDTH must be a multiple of STAGES");
  end

  // Per-stage registers; a/b carry the not-yet-added upper chunks, r the finished lower chunks.
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic [WIDTH-1:0]  r_d [STAGES];
  logic              ovf_q, ovf_d;
`ifdef ADDSUB_PIPE_SAT_EN
  logic [STAGES-1:0] s_q, s_d, si;
`endif

  // Stage-input views: what each stage would capture on advance.
  logic [STAGES-1:0] vi, ci;
  logic [WIDTH-1:0]  ai [STAGES];
  logic [WIDTH-1:0]  bi [STAGES];
  logic [WIDTH-1:0]  ri [STAGES];

  logic [STAGES:0]   adv;

  // A stage may advance if it is empty or the stage after it advances; collapses bubbles.
  always_comb begin : p_adv
    adv         = '0;
    adv[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k] = ~v_q[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  always_comb begin : p_stage_in
    vi = '0;
    ci = '0;
    ai = '{default: '0};
    bi = '{default: '0};
    ri = '{default: '0};
`ifdef ADDSUB_PIPE_SAT_EN
    si    = '0;
    si[0] = sat;
`endif
    vi[0] = in_valid;
    ci[0] = carry_in;
    ai[0] = op1;
    bi[0] = sub ? ~op2 : op2;
    ri[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      vi[k] = v_q[k-1];
      ci[k] = c_q[k-1];
      ai[k] = a_q[k-1];
      bi[k] = b_q[k-1];
      ri[k] = r_q[k-1];
`ifdef ADDSUB_PIPE_SAT_EN
      si[k] = s_q[k-1];
`endif
    end
  end

  always_comb begin : p_stage_next
    logic [CW:0] sum;
    sum   = '0;
    v_d   = v_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    r_d   = r_q;
    ovf_d = ovf_q;
`ifdef ADDSUB_PIPE_SAT_EN
    s_d   = s_q;
`endif
    for (int k = 0; k < int'(STAGES); k++) begin
      sum = {1'b0, ai[k][k*CW +: CW]} + {1'b0, bi[k][k*CW +: CW]} + {{CW{1'b0}}, ci[k]};
      if (adv[k]) begin
        v_d[k] = vi[k];
        // Payload only moves with a real beat so idle outputs keep their last value.
        if (vi[k]) begin
          a_d[k]              = ai[k];
          b_d[k]              = bi[k];
          r_d[k]              = ri[k];
          r_d[k][k*CW +: CW]  = sum[CW-1:0];
          c_d[k]              = sum[CW];
`ifdef ADDSUB_PIPE_SAT_EN
          s_d[k]              = si[k];
`endif
        end
      end
    end
    if (adv[Last] && vi[Last]) begin
      ovf_d = (ai[Last][WIDTH-1] == bi[Last][WIDTH-1]) &&
              (r_d[Last][WIDTH-1] != ai[Last][WIDTH-1]);
`ifdef ADDSUB_PIPE_SAT_EN
      if (si[Last] && ovf_d) begin
        r_d[Last] = ai[Last][WIDTH-1] ? SMin : SMax;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '{default: '0};
      b_q   <= '{default: '0};
      r_q   <= '{default: '0};
      ovf_q <= 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
      s_q   <= '0;
`endif
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      ovf_q <= ovf_d;
`ifdef ADDSUB_PIPE_SAT_EN
      s_q   <= s_d;
`endif
    end
  end

  assign out_valid = v_q[Last];
  assign result    = r_q[Last];
  assign carry_out = c_q[Last];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=64, STAGES=4): directed vectors, backpressure,
// random streaming against a 65-bit reference add, and mid-stream reset.
module tb_addsub_pipe;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned STAGES = 4;
`ifdef ADDSUB_PIPE_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op1 = '0;
  logic [WIDTH-1:0] op2 = '0;
  logic             sub = 1'b0;
  logic             carry_in = 1'b0;
  logic             sat = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  int n_vec = 0;
  int n_err = 0;
  int cycles;
  int seen;

  always #5 clk = ~clk;

  addsub_pipe #(
    .WIDTH (WIDTH),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .sub      (sub),
    .carry_in (carry_in),
`ifdef ADDSUB_PIPE_SAT_EN
    .sat      (sat),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s, input logic ci, input logic st);
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;
    exp_t             e;
    bx   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
    e.r  = full[WIDTH-1:0];
    e.c  = full[WIDTH];
    e.o  = (a[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    if (SatEn && st && e.o) e.r = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(WIDTH-1){1'b0}}};
      3:       return {1'b0, {(WIDTH-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One beat into an idle pipe; checks latency and the result fields.
  task automatic send_one(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic ci, input logic st,
                          input logic [WIDTH-1:0] er, input logic ec, input logic eo);
    int lat;
    op1 = a; op2 = b; sub = s; carry_in = ci; sat = st;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "/in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, STAGES);
    check({tag, "/result"}, result, er);
    check({tag, "/carry"}, carry_out, ec);
    check({tag, "/ovf"}, overflow, eo);
    @(posedge clk); #1;
    sat = 1'b0;
  endtask

  // Streams n beats through a scoreboard. directed: A=B=i, out_ready low in cycles 3..9.
  task automatic run_stream(input string tag, input int n, input int vld_pct, input int rdy_pct,
                            input bit directed, output int cyc);
    exp_t             q[$];
    exp_t             e;
    int               sent, got, low_seen;
    bit               stalled, pend;
    logic [WIDTH-1:0] held;
    sent = 0; got = 0; low_seen = 0; cyc = 0;
    stalled = 1'b0; pend = 1'b0; held = '0;
    while ((sent < n || q.size() != 0) && cyc < 20 * n + 100) begin
      if (directed) out_ready = !(cyc >= 3 && cyc <= 9);
      else          out_ready = ($urandom_range(99) < rdy_pct);
      if (sent < n && !pend) begin
        if (directed) begin
          op1 = WIDTH'(sent); op2 = WIDTH'(sent); sub = 1'b0; carry_in = 1'b0; sat = 1'b0;
          pend = 1'b1;
        end else if ($urandom_range(99) < vld_pct) begin
          op1 = rnd_op(); op2 = rnd_op();
          sub = 1'($urandom_range(1)); carry_in = 1'($urandom_range(1));
          sat = 1'($urandom_range(1));
          pend = 1'b1;
        end
      end
      in_valid = pend;
      #1;
      check({tag, "/in_ready"}, in_ready, (q.size() < int'(STAGES)) || out_ready);
      if (!in_ready) low_seen++;
      if (stalled) begin
        check({tag, "/hold_valid"}, out_valid, 1'b1);
        check({tag, "/hold_result"}, result, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check({tag, "/no_extra"}, out_valid, 1'b0);
        end else begin
          e = q.pop_front();
          if (directed) check({tag, "/2i"}, result, WIDTH'(2 * got));
          check({tag, "/result"}, result, e.r);
          check({tag, "/carry"}, carry_out, e.c);
          check({tag, "/ovf"}, overflow, e.o);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(op1, op2, sub, carry_in, sat));
        sent++;
        pend = 1'b0;
      end
      stalled = out_valid && !out_ready;
      held    = result;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    sat      = 1'b0;
    check({tag, "/sent"}, sent, n);
    check({tag, "/drained"}, q.size(), 0);
    if (directed) check({tag, "/in_ready_drop"}, low_seen != 0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst/in_ready", in_ready, 1'b1);
    check("rst/out_valid", out_valid, 1'b0);
    check("rst/result", result, 64'd0);
    check("rst/carry", carry_out, 1'b0);
    check("rst/ovf", overflow, 1'b0);

    send_one("add_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0,
             64'd0, 1'b1, 1'b0);
    send_one("sub_neg", 64'd5, 64'd7, 1'b1, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send_one("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    send_one("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send_one("chunk_carry", 64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0,
             64'h0001_0000_0000_0000, 1'b0, 1'b0);
    send_one("add_cin", 64'd1, 64'd2, 1'b0, 1'b1, 1'b0, 64'd4, 1'b0, 1'b0);
`ifdef ADDSUB_PIPE_SAT_EN
    send_one("sat_max", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    send_one("sat_off", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send_one("sat_min", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1,
             64'h8000_0000_0000_0000, 1'b1, 1'b1);
`endif

    run_stream("bp", 8, 100, 100, 1'b1, cycles);
    run_stream("rand", 1000, 70, 50, 1'b0, cycles);
    run_stream("tput", 50, 100, 100, 1'b0, cycles);
    check("tput/cycles", cycles, 50 + STAGES);

    // Three beats in flight, then asynchronous reset between clock edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op1 = 64'h1111 * (i + 1); op2 = 64'h2222; sub = 1'b0; carry_in = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst/out_valid", out_valid, 1'b0);
    check("mid_rst/result", result, 64'd0);
    check("mid_rst/carry", carry_out, 1'b0);
    check("mid_rst/ovf", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    check("mid_rst/in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("mid_rst/no_beat", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
